cpu_bus_guard: RTL and testbench

// Registered bus stage between the picorv32 native memory port and the
// top-level address decoder/read-data mux. Captures each CPU request and

---
 rtl/cpu_bus_guard.sv | 154 +++++++++++++++
 tb/tb_cpu_bus_guard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_guard.sv
// Registered bus stage between the picorv32 native memory port and the address decoder.
// Completes accesses the decoder never acknowledges and records each such timeout.
`timescale 1ns/1ps
module cpu_bus_guard #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_addr,
    output logic [31:0] dec_wdata,
    output logic [3:0]  dec_wstrb,
    input  logic        dec_ready,
    input  logic [31:0] dec_rdata,
    input  logic        clear_fault,
    output logic        timeout_event,
    output logic        fault_flag,
    output logic [31:0] fault_addr,
    output logic [7:0]  fault_count
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned FCNT_W = 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               cpu_ready_d;
    logic [DATA_W-1:0]  cpu_rdata_d;
    logic               dec_valid_d;
    logic [ADDR_W-1:0]  dec_addr_d;
    logic [DATA_W-1:0]  dec_wdata_d;
    logic [STRB_W-1:0]  dec_wstrb_d;
    logic               timeout_event_d;
    logic               fault_flag_d;
    logic [ADDR_W-1:0]  fault_addr_d;
    logic [FCNT_W-1:0]  fault_count_d;

    // State and every output are registered from the next-state values below.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cpu_ready     <= 1'b0;
            cpu_rdata     <= '0;
            dec_valid     <= 1'b0;
            dec_addr      <= '0;
            dec_wdata     <= '0;
            dec_wstrb     <= '0;
            timeout_event <= 1'b0;
            fault_flag    <= 1'b0;
            fault_addr    <= '0;
            fault_count   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cpu_ready     <= cpu_ready_d;
            cpu_rdata     <= cpu_rdata_d;
            dec_valid     <= dec_valid_d;
            dec_addr      <= dec_addr_d;
            dec_wdata     <= dec_wdata_d;
            dec_wstrb     <= dec_wstrb_d;
            timeout_event <= timeout_event_d;
            fault_flag    <= fault_flag_d;
            fault_addr    <= fault_addr_d;
            fault_count   <= fault_count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cpu_ready_d     = 1'b0;
        cpu_rdata_d     = cpu_rdata;
        dec_valid_d     = 1'b0;
        dec_addr_d      = dec_addr;
        dec_wdata_d     = dec_wdata;
        dec_wstrb_d     = dec_wstrb;
        timeout_event_d = 1'b0;
        fault_flag_d    = fault_flag;
        fault_addr_d    = fault_addr;
        fault_count_d   = fault_count;

        // Clear first so a coincident timeout still lands as the first new fault.
        if (clear_fault) begin
            fault_flag_d  = 1'b0;
            fault_count_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    dec_addr_d  = cpu_addr;
                    dec_wdata_d = cpu_wdata;
                    dec_wstrb_d = cpu_wstrb;
                    cnt_d       = '0;
                    dec_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                dec_valid_d = 1'b1;
                if (dec_ready) begin
                    cpu_rdata_d = dec_rdata;
                    dec_valid_d = 1'b0;
                    cpu_ready_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cpu_rdata_d     = TIMEOUT_RDATA;
                    dec_valid_d     = 1'b0;
                    cpu_ready_d     = 1'b1;
                    timeout_event_d = 1'b1;
                    fault_flag_d    = 1'b1;
                    fault_addr_d    = dec_addr;
                    if (fault_count_d != FCNT_MAX) begin
                        fault_count_d = fault_count_d + FCNT_W'(1);
                    end
                    state_d         = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_guard.sv
// Scoreboard bench for cpu_bus_guard: expected completions are queued at request time
// and compared when cpu_ready pulses; fault registers are tracked by a small model.
`timescale 1ns/1ps
module tb_cpu_bus_guard;

    localparam int unsigned TC  = 8;
    localparam logic [31:0] TRD = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        dec_valid;
    logic [31:0] dec_addr;
    logic [31:0] dec_wdata;
    logic [3:0]  dec_wstrb;
    logic        dec_ready;
    logic [31:0] dec_rdata;
    logic        clear_fault;
    logic        timeout_event;
    logic        fault_flag;
    logic [31:0] fault_addr;
    logic [7:0]  fault_count;

    cpu_bus_guard #(
        .TIMEOUT_CYCLES (TC),
        .TIMEOUT_RDATA  (TRD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_valid     (cpu_valid),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_ready     (cpu_ready),
        .cpu_rdata     (cpu_rdata),
        .dec_valid     (dec_valid),
        .dec_addr      (dec_addr),
        .dec_wdata     (dec_wdata),
        .dec_wstrb     (dec_wstrb),
        .dec_ready     (dec_ready),
        .dec_rdata     (dec_rdata),
        .clear_fault   (clear_fault),
        .timeout_event (timeout_event),
        .fault_flag    (fault_flag),
        .fault_addr    (fault_addr),
        .fault_count   (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        tev;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          exp_fcount = 0;
    logic        exp_fflag  = 1'b0;
    logic [31:0] exp_faddr  = 32'h0;
    int          tev_seen   = 0;
    int          tev_exp    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Completion monitor: every cpu_ready must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (timeout_event) tev_seen++;
            if (cpu_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 32'(cpu_ready), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rdata", cpu_rdata, mon_e.rdata);
                    check("tev_at_ready", 32'(timeout_event), 32'(mon_e.tev));
                end
            end
        end
    end

    // One CPU access; ready_after = REQ-cycle index carrying dec_ready, <0 = never.
    task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             input int ready_after, input logic [31:0] rd,
                             input bit clr_at_to, input bit late_ready);
        bit   timed_out;
        int   nreq;
        int   budget;
        exp_t e;
        timed_out = !(ready_after >= 0 && ready_after < int'(TC));
        e.rdata   = timed_out ? TRD : rd;
        e.tev     = timed_out;
        sb_q.push_back(e);
        if (timed_out) begin
            tev_exp++;
            exp_fcount = clr_at_to ? 1 : ((exp_fcount == 255) ? 255 : exp_fcount + 1);
            exp_fflag  = 1'b1;
            exp_faddr  = a;
        end
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wstrb = ws;
        nreq      = 0;
        budget    = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                dec_ready   = 1'b0;
                clear_fault = 1'b0;
                break;
            end
            budget++;
            if (budget > int'(4 * TC) + 20) begin
                check("ready_wait_expired", 32'd0, 32'd1);
                break;
            end
            check("dec_valid_in_access", 32'(dec_valid), 32'd1);
            check("dec_addr", dec_addr, a);
            check("dec_wdata", dec_wdata, wd);
            check("dec_wstrb", 32'(dec_wstrb), 32'(ws));
            dec_ready   = (nreq == ready_after);
            dec_rdata   = dec_ready ? rd : $urandom;
            clear_fault = clr_at_to && (nreq == int'(TC) - 1);
            nreq++;
        end
        check("dec_valid_cycles", 32'(nreq), 32'(timed_out ? int'(TC) : ready_after + 1));
        @(negedge clk);
        cpu_valid = 1'b0;
        cpu_addr  = $urandom;
        check("ready_one_cycle", 32'(cpu_ready), 32'd0);
        check("dec_valid_after", 32'(dec_valid), 32'd0);
        check("tev_one_cycle", 32'(timeout_event), 32'd0);
        check("fault_count", 32'(fault_count), 32'(exp_fcount));
        check("fault_flag", 32'(fault_flag), 32'(exp_fflag));
        check("fault_addr", fault_addr, exp_faddr);
        if (late_ready) begin
            dec_ready = 1'b1;
            dec_rdata = 32'h0BAD_0BAD;
            @(negedge clk);
            dec_ready = 1'b0;
            @(negedge clk);
            check("late_ready_rdata", cpu_rdata, e.rdata);
            check("late_ready_dec_valid", 32'(dec_valid), 32'd0);
        end
        @(negedge clk);
        check("no_reaccept", 32'(dec_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        cpu_valid   = 1'b0;
        cpu_addr    = 32'h0;
        cpu_wdata   = 32'h0;
        cpu_wstrb   = 4'h0;
        dec_ready   = 1'b0;
        dec_rdata   = 32'h0;
        clear_fault = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_dec_addr", dec_addr, 32'h0);
        check("rst_fault", {fault_addr[23:0], fault_count}, 32'h0);
        check("rst_flag_tev", {30'd0, fault_flag, timeout_event}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Normal read, ready in the fourth REQ cycle.
        do_access(32'h4000_0010, 32'h0, 4'b0000, 3, 32'h1234_5678, 1'b0, 1'b0);
        // Fastest path: ready in the first REQ cycle.
        do_access(32'h4000_0014, 32'h0, 4'b0000, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
        // Write is forwarded unchanged.
        do_access(32'h4000_0004, 32'hA5A5_5A5A, 4'b0011, 2, 32'h5555_AAAA, 1'b0, 1'b0);
        // Ready in the final cycle wins over the timeout.
        do_access(32'h4000_0018, 32'h0, 4'b0000, int'(TC) - 1, 32'h7777_1111, 1'b0, 1'b0);
        // Unmapped read times out.
        do_access(32'hC500_0000, 32'h0, 4'b0000, -1, 32'h0, 1'b0, 1'b0);
        // Timeout followed by a late ready that must be ignored.
        do_access(32'hC500_0040, 32'h0, 4'b0000, -1, 32'h0, 1'b0, 1'b1);
        // Timed-out write still completes to the CPU.
        do_access(32'hC500_0080, 32'h1111_2222, 4'b1111, -1, 32'h0, 1'b0, 1'b0);

        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        exp_fcount  = 0;
        exp_fflag   = 1'b0;
        check("clear_count", 32'(fault_count), 32'd0);
        check("clear_flag", 32'(fault_flag), 32'd0);
        check("clear_keeps_addr", fault_addr, exp_faddr);

        for (int i = 0; i < 260; i++) begin
            do_access(32'hC600_0000 + 32'(i) * 32'd4, 32'h0, 4'b0000, -1, 32'h0, 1'b0, 1'b0);
        end
        check("sat_count", 32'(fault_count), 32'd255);
        do_access(32'hC700_0000, 32'h0, 4'b0000, -1, 32'h0, 1'b1, 1'b0);
        check("clear_with_timeout_count", 32'(fault_count), 32'd1);
        check("clear_with_timeout_flag", 32'(fault_flag), 32'd1);

        // Reset during the second REQ cycle abandons the access.
        cpu_valid = 1'b1;
        cpu_addr  = 32'h4000_0020;
        cpu_wstrb = 4'b0000;
        @(negedge clk);
        check("pre_rst_req0", 32'(dec_valid), 32'd1);
        @(negedge clk);
        check("pre_rst_req1", 32'(dec_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_dec_valid", 32'(dec_valid), 32'd0);
        check("async_rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("async_rst_fault_count", 32'(fault_count), 32'd0);
        check("async_rst_fault_addr", fault_addr, 32'h0);
        exp_fcount = 0;
        exp_fflag  = 1'b0;
        exp_faddr  = 32'h0;
        cpu_valid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(dec_valid), 32'd0);
        do_access(32'h4000_0024, 32'h0, 4'b0000, 1, 32'h0F0F_0F0F, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("tev_total", 32'(tev_seen), 32'(tev_exp));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
